// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM write-burst path:
//   - burst FSM state constants (2-bit encoding)
//   - default full-burst length
//   - wrap_addr(): next burst start address inside the circular region
//     [base, end_a]. The arithmetic is done one bit wider than any supported
//     address so that "start + len + burst - 1" can never overflow.
//     Address widths up to 31 bits are supported.
// -----------------------------------------------------------------------------
package sdram_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t REQ  = 2'd1;
  localparam state_t DATA = 2'd2;
  localparam state_t DONE = 2'd3;

  localparam int BURST_LEN_DEF = 8;

  // A following full burst must fit entirely below end_a. If it would not,
  // restart at base, so no burst ever straddles the end of the region.
  function automatic logic [31:0] wrap_addr(
    input logic [31:0] cur,
    input logic [31:0] len,
    input logic [31:0] base,
    input logic [31:0] end_a,
    input logic [31:0] burst_len
  );
    logic [32:0] nxt;
    logic [32:0] last;
    nxt  = {1'b0, cur} + {1'b0, len};
    last = nxt + {1'b0, burst_len} - 33'd1;
    if (last > {1'b0, end_a}) begin
      return base;
    end
    return nxt[31:0];
  endfunction

endpackage

// File: rtl/sdram_addr_gen.sv
// -----------------------------------------------------------------------------
// sdram_addr_gen
// Holds the running burst start pointer for the circular write region.
// Until the first burst is issued after reset the pointer follows base_addr;
// from then on it only moves when a burst completes (advance), stepping by
// the burst length and wrapping back to base_addr when the next full burst
// would not fit below end_addr.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   base_addr   : start of circular region
//   end_addr    : last valid word of region (inclusive)
//   in_idle     : burst FSM is in IDLE
//   issue       : a burst is being issued this cycle (IDLE -> REQ)
//   advance     : burst finished this cycle (DONE)
//   len         : word count of the burst that just finished
//   cur_addr    : current burst start address
// -----------------------------------------------------------------------------
module sdram_addr_gen
  import sdram_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int LEN_W      = 9,
  parameter int BURST_LEN  = BURST_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic                  in_idle,
  input  logic                  issue,
  input  logic                  advance,
  input  logic [LEN_W-1:0]      len,
  output logic [ADDR_WIDTH-1:0] cur_addr
);

  logic started;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr <= '0;
      started  <= 1'b0;
    end else begin
      if (advance) begin
        cur_addr <= ADDR_WIDTH'(wrap_addr(32'(cur_addr), 32'(len), 32'(base_addr),
                                          32'(end_addr), 32'(BURST_LEN)));
      end else if (in_idle && !started) begin
        cur_addr <= base_addr;
      end
      if (issue) begin
        started <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_wr_burst.sv
// -----------------------------------------------------------------------------
// sdram_wr_burst
// Drains a show-ahead write FIFO into fixed-length SDRAM write bursts.
// IDLE waits for a full burst worth of data, REQ holds the request until the
// controller acks, DATA forwards words as the controller pulls them
// (zero-latency: sdr_wr_data is the FIFO head word), DONE pulses burst_done
// and advances the circular address pointer.
//
// Optional feature (macro SDRAM_WR_FLUSH_EN): a flush pulse lets the
// remaining (< BURST_LEN) words go out as one partial burst. Without the
// macro the flush port is ignored and every burst is BURST_LEN words.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   enable            : allow new bursts to start
//   flush             : request a partial burst of the remaining data
//   base_addr/end_addr: circular region (end inclusive)
//   fifo_rd_req       : FIFO pop strobe
//   fifo_rd_data      : FIFO head word (show-ahead)
//   fifo_rd_num       : FIFO fill level
//   fifo_rd_empty     : FIFO empty flag
//   sdr_wr_req        : burst request, held until sdr_wr_ack
//   sdr_wr_ack        : one-cycle acceptance
//   sdr_wr_addr       : burst start address
//   sdr_wr_len        : burst word count
//   sdr_wr_data_req   : controller pulls one word this cycle
//   sdr_wr_data       : write word
//   busy              : not in IDLE
//   burst_done        : one-cycle pulse after the last word is pulled
// -----------------------------------------------------------------------------
module sdram_wr_burst
  import sdram_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 24,
  parameter int DEPTH_W    = 10,
  parameter int BURST_LEN  = BURST_LEN_DEF,
  parameter int LEN_W      = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  output logic                  fifo_rd_req,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic [DEPTH_W-1:0]    fifo_rd_num,
  input  logic                  fifo_rd_empty,
  output logic                  sdr_wr_req,
  input  logic                  sdr_wr_ack,
  output logic [ADDR_WIDTH-1:0] sdr_wr_addr,
  output logic [LEN_W-1:0]      sdr_wr_len,
  input  logic                  sdr_wr_data_req,
  output logic [DATA_WIDTH-1:0] sdr_wr_data,
  output logic                  busy,
  output logic                  burst_done
);

  localparam logic [DEPTH_W:0] BL_LVL = (DEPTH_W + 1)'(BURST_LEN);
  localparam logic [LEN_W-1:0] BL_LEN = LEN_W'(BURST_LEN);

  state_t                  state;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        beat;
  logic                    err;
  logic [ADDR_WIDTH-1:0]   cur_addr;

  logic lvl_full;
  logic start_full;
  logic start_part;
  logic pull;
  logic pop;
  logic underrun;

  assign lvl_full = ({1'b0, fifo_rd_num} >= BL_LVL);

`ifdef SDRAM_WR_FLUSH_EN
  logic flush_pend;
  logic flush_clr;

  always_comb begin
    start_part = (state == IDLE) && enable && flush_pend && !lvl_full && !fifo_rd_empty;
    // An empty FIFO leaves nothing to flush, so the request is dropped.
    flush_clr  = start_part || ((state == IDLE) && fifo_rd_empty);
  end

  // A new flush pulse wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend <= 1'b0;
    end else begin
      flush_pend <= flush || (flush_pend && !flush_clr);
    end
  end
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign start_part   = 1'b0;
`endif

  always_comb begin
    start_full = (state == IDLE) && enable && lvl_full;
    pull       = (state == DATA) && sdr_wr_data_req && (beat < len_q);
    pop        = pull && !fifo_rd_empty;
    underrun   = pull && fifo_rd_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      len_q <= '0;
      beat  <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_full) begin
            len_q <= BL_LEN;
            state <= REQ;
          end else if (start_part) begin
            len_q <= LEN_W'(fifo_rd_num);
            state <= REQ;
          end
        end
        REQ: begin
          if (sdr_wr_ack) begin
            beat  <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          // An underrun holds the beat count; the word is simply not supplied.
          if (pop) begin
            beat <= beat + 1'b1;
            if (beat == len_q - 1'b1) begin
              state <= DONE;
            end
          end
          if (underrun) begin
            err <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  sdram_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_W      (LEN_W),
    .BURST_LEN  (BURST_LEN)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .base_addr (base_addr),
    .end_addr  (end_addr),
    .in_idle   (state == IDLE),
    .issue     (start_full || start_part),
    .advance   (state == DONE),
    .len       (len_q),
    .cur_addr  (cur_addr)
  );

  // All strobes decode directly from the registered state so they drop as
  // soon as rst_n asserts.
  assign fifo_rd_req = pop;
  assign sdr_wr_req  = (state == REQ);
  assign sdr_wr_addr = cur_addr;
  assign sdr_wr_len  = len_q;
  assign sdr_wr_data = fifo_rd_data;
  assign busy        = (state != IDLE);
  assign burst_done  = (state == DONE);

  ap_no_underrun: assert property (@(posedge clk) disable iff (!rst_n) !err);
  ap_no_empty_pop: assert property (@(posedge clk) disable iff (!rst_n)
                                    !(fifo_rd_req && fifo_rd_empty));

endmodule

// File: tb/tb_sdram_wr_burst.sv
`timescale 1ns/1ps
module tb_sdram_wr_burst;

  localparam int DW  = 16;
  localparam int AW  = 24;
  localparam int DPW = 10;
  localparam int BL  = 8;
  localparam int LW  = 9;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          flush;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] end_addr;
  logic          fifo_rd_req;
  logic [DW-1:0] fifo_rd_data;
  logic [DPW-1:0] fifo_rd_num;
  logic          fifo_rd_empty;
  logic          sdr_wr_req;
  logic          sdr_wr_ack;
  logic [AW-1:0] sdr_wr_addr;
  logic [LW-1:0] sdr_wr_len;
  logic          sdr_wr_data_req;
  logic [DW-1:0] sdr_wr_data;
  logic          busy;
  logic          burst_done;

  sdram_wr_burst #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_W(DPW), .BURST_LEN(BL), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .base_addr(base_addr), .end_addr(end_addr),
    .fifo_rd_req(fifo_rd_req), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_num(fifo_rd_num), .fifo_rd_empty(fifo_rd_empty),
    .sdr_wr_req(sdr_wr_req), .sdr_wr_ack(sdr_wr_ack),
    .sdr_wr_addr(sdr_wr_addr), .sdr_wr_len(sdr_wr_len),
    .sdr_wr_data_req(sdr_wr_data_req), .sdr_wr_data(sdr_wr_data),
    .busy(busy), .burst_done(burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Bench FIFO contents, scoreboard of expected write words, pending pushes.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] push_q[$];

  // Logs recorded by the model for literal pinning.
  longint addr_log[$];
  int     len_log[$];
  logic [DW-1:0] data_log[$];

  // Protocol-level model: phase 0 idle, 1 request, 2 data, 3 done.
  int     ph = 0;
  int     started = 0;
  longint m_addr = 0;
  longint req_addr = 0;
  int     m_len = 0;
  int     m_pulls = 0;
  int     fp = 0;
  int     mode = 0;     // 0 pull every cycle, 1 alternate, 2 random
  int     ack_wait = 0;
  bit     ack_n = 0, dr_n = 0, alt = 1, pop_pending = 0;
  int     cyc = 0, first_pop_cyc = 0, last_pop_cyc = 0, done_cyc = 0;
  int     req_hi_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    chk("rst_busy", busy, 0);
    chk("rst_req", sdr_wr_req, 0);
    chk("rst_pop", fifo_rd_req, 0);
    chk("rst_done", burst_done, 0);
    chk("rst_addr", sdr_wr_addr, 0);
    chk("rst_len", sdr_wr_len, 0);
    ph = 0; started = 0; fp = 0; m_pulls = 0;
    pop_pending = 0; ack_n = 0; dr_n = 0; ack_wait = 0; alt = 1;
  endtask

  task automatic model_step();
    int  num;
    int  nph;
    bit  e_pop;
    bit  clr;
    longint nxt;
    num = fq.size();
    nph = ph;
    clr = 0;
    e_pop = (ph == 2) && sdr_wr_data_req && (m_pulls < m_len) && (num > 0);
    chk("fifo_rd_req", fifo_rd_req, e_pop);
    chk("sdr_wr_req", sdr_wr_req, ph == 1);
    chk("busy", busy, ph != 0);
    chk("burst_done", burst_done, ph == 3);
    if (sdr_wr_req) req_hi_cnt++;
    if (ph == 1) begin
      chk("sdr_wr_addr", sdr_wr_addr, req_addr);
      chk("sdr_wr_len", sdr_wr_len, m_len);
    end
    if (e_pop) begin
      chk("sdr_wr_data", sdr_wr_data, sb[0]);
      data_log.push_back(sb.pop_front());
      pop_pending = 1;
      if (m_pulls == 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
    case (ph)
      0: begin
        if (!started) m_addr = base_addr;
        if (enable && num >= BL) begin
          nph = 1; m_len = BL;
        end
`ifdef SDRAM_WR_FLUSH_EN
        else if (enable && fp != 0 && num > 0) begin
          nph = 1; m_len = num; clr = 1;
        end
        if (num == 0) clr = 1;
`endif
        if (nph == 1) begin
          started = 1;
          req_addr = m_addr;
          addr_log.push_back(m_addr);
          len_log.push_back(m_len);
        end
      end
      1: if (sdr_wr_ack) begin nph = 2; m_pulls = 0; end
      2: begin
        if (e_pop) begin
          m_pulls++;
          if (m_pulls == m_len) nph = 3;
        end
      end
      default: begin
        done_cyc = cyc;
        nxt = m_addr + m_len;
        if (nxt + BL - 1 > longint'(end_addr)) m_addr = base_addr;
        else m_addr = nxt & ((64'd1 << AW) - 1);
        nph = 0;
      end
    endcase
`ifdef SDRAM_WR_FLUSH_EN
    fp = (flush === 1'b1) ? 1 : ((fp != 0 && !clr) ? 1 : 0);
`endif
    // Controller behaviour for the next cycle.
    ack_n = 0;
    if (sdr_wr_req && !sdr_wr_ack) begin
      if (ack_wait <= 0) ack_n = 1;
      else ack_wait--;
    end else if (!sdr_wr_req) begin
      ack_wait = (mode == 2) ? int'($urandom_range(0, 3)) : 0;
    end
    if (nph == 2) begin
      case (mode)
        0: dr_n = 1;
        1: begin dr_n = alt; alt = !alt; end
        default: dr_n = $urandom_range(0, 1) == 1;
      endcase
    end else begin
      alt = 1;
      dr_n = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    ph = nph;
  endtask

  task automatic apply();
    logic [DW-1:0] w;
    if (pop_pending) begin
      void'(fq.pop_front());
      pop_pending = 0;
    end
    while (push_q.size() > 0) begin
      w = push_q.pop_front();
      fq.push_back(w);
      sb.push_back(w);
    end
    sdr_wr_ack      = ack_n;
    sdr_wr_data_req = dr_n;
    fifo_rd_data    = (fq.size() > 0) ? fq[0] : '0;
    fifo_rd_num     = DPW'(fq.size());
    fifo_rd_empty   = (fq.size() == 0);
  endtask

  initial begin : env
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) model_reset();
      else model_step();
      @(posedge clk);
      #1;
      apply();
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [AW-1:0] b, input logic [AW-1:0] e);
    tick();
    rst_n = 1'b0;
    base_addr = b;
    end_addr = e;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push_words(input int n, input logic [DW-1:0] first);
    for (int i = 0; i < n; i++) push_q.push_back(first + DW'(i));
  endtask

  function automatic bit quiet();
    bit q;
    q = (ph == 0) && (push_q.size() == 0) && (fq.size() < BL);
`ifdef SDRAM_WR_FLUSH_EN
    if (fp != 0 && fq.size() > 0 && enable) q = 0;
`endif
    return q;
  endfunction

  task automatic wait_quiet(input int limit, input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!quiet() && n < limit);
    chk({name, "_timeout"}, n >= limit, 0);
  endtask

  initial begin : watchdog
    #3000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : test
    int a0, d0, r0, got, words, n;
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0;
    base_addr = 24'h100; end_addr = 24'h00FFFF;
    sdr_wr_ack = 1'b0; sdr_wr_data_req = 1'b0;
    fifo_rd_data = '0; fifo_rd_num = '0; fifo_rd_empty = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    enable = 1'b1;

    // Full burst with continuous pull.
    mode = 0;
    a0 = addr_log.size(); d0 = data_log.size();
    push_words(8, 16'h1000);
    wait_quiet(200, "full");
    chk("full_addr", addr_log[a0], 24'h100);
    chk("full_len", len_log[a0], 8);
    for (int i = 0; i < 8; i++) chk("full_data", data_log[d0 + i], 16'h1000 + i);
    chk("full_pull_span", last_pop_cyc - first_pop_cyc, 7);
    chk("full_done_delay", done_cyc - last_pop_cyc, 1);

    // Throttled pull.
    mode = 1;
    a0 = addr_log.size(); d0 = data_log.size();
    push_words(8, 16'h1000);
    wait_quiet(200, "throttle");
    chk("thr_addr", addr_log[a0], 24'h108);
    for (int i = 0; i < 8; i++) chk("thr_data", data_log[d0 + i], 16'h1000 + i);
    chk("thr_pull_span", last_pop_cyc - first_pop_cyc, 14);
    chk("thr_done_delay", done_cyc - last_pop_cyc, 1);

    // Wrap inside [0x100, 0x117].
    mode = 0;
    do_reset(24'h100, 24'h117);
    a0 = addr_log.size();
    push_words(32, 16'h3000);
    wait_quiet(400, "wrap");
    chk("wrap_addr0", addr_log[a0], 24'h100);
    chk("wrap_addr1", addr_log[a0 + 1], 24'h108);
    chk("wrap_addr2", addr_log[a0 + 2], 24'h110);
    chk("wrap_addr3", addr_log[a0 + 3], 24'h100);

    // Top of the address space: the next-burst compare must not overflow.
    mode = 2;
    do_reset(24'hFFFFF0, 24'hFFFFFF);
    a0 = addr_log.size();
    push_words(24, 16'h4000);
    wait_quiet(600, "top");
    chk("top_addr0", addr_log[a0], 24'hFFFFF0);
    chk("top_addr1", addr_log[a0 + 1], 24'hFFFFF8);
    chk("top_addr2", addr_log[a0 + 2], 24'hFFFFF0);

    // Randomized traffic, regions and enable.
    for (int it = 0; it < 4; it++) begin
      logic [AW-1:0] b;
      b = AW'($urandom_range(0, 24'h0FFFFF));
      do_reset(b, b + AW'($urandom_range(7, 60)));
      words = 8 * int'($urandom_range(2, 6));
      while (words > 0) begin
        tick();
        enable = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1) begin
          n = int'($urandom_range(1, 5));
          if (n > words) n = words;
          for (int k = 0; k < n; k++) push_q.push_back(DW'($urandom));
          words -= n;
        end
      end
      enable = 1'b1;
      wait_quiet(2000, "random");
      chk("random_drained", fq.size(), 0);
    end

    // Threshold hold: 7 words never start a burst, the 8th does promptly.
    mode = 0;
    push_words(7, 16'h6000);
    tick();
    r0 = req_hi_cnt;
    repeat (100) tick();
    chk("hold_req_cycles", req_hi_cnt - r0, 0);
    push_words(1, 16'h6007);
    got = 0;
    for (int i = 0; i < 2 && got == 0; i++) begin
      tick();
      if (sdr_wr_req) got = 1;
    end
    chk("hold_req_within_2", got, 1);
    wait_quiet(200, "hold");

    // Flush of a partial burst.
    do_reset(24'h200, 24'h2FF);
    a0 = addr_log.size();
    push_words(3, 16'h5000);
    repeat (5) tick();
    r0 = req_hi_cnt;
    flush = 1'b1;
    tick();
    flush = 1'b0;
`ifdef SDRAM_WR_FLUSH_EN
    wait_quiet(200, "flush");
    chk("flush_len", len_log[a0], 3);
    chk("flush_addr", addr_log[a0], 24'h200);
    chk("flush_drained", fq.size(), 0);
`else
    repeat (50) tick();
    chk("noflush_req_cycles", req_hi_cnt - r0, 0);
`endif

    // Reset in the middle of a burst.
    mode = 0;
    a0 = addr_log.size();
    push_words(8, 16'h7000);
    n = 0;
    while (!(ph == 2 && m_pulls == 4) && n < 100) begin
      tick();
      n++;
    end
    chk("midrst_timeout", n >= 100, 0);
`ifdef SDRAM_WR_FLUSH_EN
    chk("midrst_burst_addr", addr_log[a0], 24'h203);
`else
    chk("midrst_burst_addr", addr_log[a0], 24'h200);
`endif
    chk("midrst_pre_pop", fifo_rd_req, 1);
    chk("midrst_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", sdr_wr_req, 0);
    chk("midrst_pop", fifo_rd_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", burst_done, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_idle", busy, 0);
    chk("midrst_addr_base", sdr_wr_addr, 24'h200);
    repeat (20) tick();
    chk("midrst_stay_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_wr_burst.md
Name: sdram_wr_burst

Overview:
- Drains the write-side data FIFO and issues fixed-length write bursts to the SDRAM command/timing controller.
- Sits directly downstream of the write-path FIFO read port and upstream of the SDRAM controller's write-request/data-pull interface.
- Generates the burst address sequence over a circular buffer `[base_addr, end_addr]`.
- Single clock domain: the FIFO read side and the controller share `clk`.

Parameters:
- `DATA_WIDTH`, 16: FIFO and SDRAM data width.
- `ADDR_WIDTH`, 24: SDRAM word address width (bank+row+col flattened).
- `DEPTH_W`, 10: width of the FIFO fill-level input.
- `BURST_LEN`, 8: words per full burst; power of two, at most 256.
- `LEN_W`, 9: width of the burst-length output; must be ≥ clog2(`BURST_LEN`)+1.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `enable` in 1: level; 0 = no new bursts started (a burst in progress completes).
- `flush` in 1: pulse; request a partial burst of remaining data (see Optional Feature).
- `base_addr` in `ADDR_WIDTH`: start of circular region, sampled in IDLE.
- `end_addr` in `ADDR_WIDTH`: last valid word of region, inclusive.
- `fifo_rd_req` out 1: pop strobe to FIFO.
- `fifo_rd_data` in `DATA_WIDTH`: show-ahead FIFO head word (valid in the same cycle as the pop).
- `fifo_rd_num` in `DEPTH_W`: FIFO fill level.
- `fifo_rd_empty` in 1: FIFO empty flag.
- `sdr_wr_req` out 1: burst write request, held until acked.
- `sdr_wr_ack` in 1: one-cycle acceptance from controller.
- `sdr_wr_addr` out `ADDR_WIDTH`: burst start address, stable while `sdr_wr_req`=1.
- `sdr_wr_len` out `LEN_W`: word count of this burst, stable while `sdr_wr_req`=1.
- `sdr_wr_data_req` in 1: controller pulls one word this cycle.
- `sdr_wr_data` out `DATA_WIDTH`: write word, combinational from `fifo_rd_data`.
- `busy` out 1: high in any state other than IDLE.
- `burst_done` out 1: one-cycle pulse after the last word of a burst is pulled.

Behaviour:
- Reset (`rst_n`=0, async): state=IDLE.
  - All outputs 0, except `sdr_wr_addr` = 0 until the first IDLE load.
  - Internal address pointer `cur_addr` loads `base_addr` on the first clock after reset release.
  - Beat counter = 0; flush-pending flag = 0.
- State IDLE:
  - `cur_addr` tracks `base_addr` only until the first burst is issued; after that it is the running pointer.
  - Go to REQ when `enable`=1 and `fifo_rd_num` ≥ `BURST_LEN`; latch `len`=`BURST_LEN`.
  - Else, if the flush rule fires, go to REQ with `len`=`fifo_rd_num`.
- State REQ:
  - `sdr_wr_req`=1; `sdr_wr_addr`=`cur_addr`; `sdr_wr_len`=`len`.
  - On `sdr_wr_ack`: drop `sdr_wr_req` the next cycle, go to DATA, beat counter=0.
  - `enable` falling during REQ does not withdraw the request.
- State DATA:
  - `fifo_rd_req` = `sdr_wr_data_req` AND beat < `len`.
  - `sdr_wr_data` = `fifo_rd_data` every cycle, so zero-latency pull.
  - Each pulled word increments beat.
  - When the pull with beat = `len`-1 occurs, go to DONE.
  - `sdr_wr_data_req` arriving with beat = `len` is ignored: no pop, `sdr_wr_data` undefined.
- State DONE (1 cycle):
  - `burst_done`=1.
  - `cur_addr` ← `nxt`, where `nxt` = `cur_addr`+`len`.
  - If `nxt`+`BURST_LEN`-1 > `end_addr` (compare at `ADDR_WIDTH`+1 bits, no overflow), `cur_addr` ← `base_addr` instead.
  - Return to IDLE. Back-to-back bursts therefore have exactly 2 idle cycles minimum (DONE, IDLE).
- FIFO protection:
  - Never assert `fifo_rd_req` when `fifo_rd_empty`=1.
  - Underrun in DATA (empty while the controller pulls) is a protocol error: hold the beat count, no pop, set sticky internal `err` (visible only via assertion).
  - The level check before REQ guarantees this cannot occur in normal operation.
- Mid-operation reset: async return to IDLE, request and pop strobes drop immediately, and the partial burst is abandoned. The controller is reset by the same `rst_n`.

Optional Feature:
- Macro: `SDRAM_WR_FLUSH_EN`.
- Defined:
  - A `flush` pulse sets flush-pending.
  - In IDLE with `enable`=1, flush-pending=1, `fifo_rd_num` < `BURST_LEN` and `fifo_rd_empty`=0, issue a partial burst with `len`=`fifo_rd_num`.
  - Flush-pending clears on entering REQ.
  - If the FIFO is empty, flush-pending clears in IDLE with no burst.
  - If `fifo_rd_num` ≥ `BURST_LEN`, a normal full burst is issued and flush-pending stays set.
- Not defined: the `flush` port exists but is ignored, and every burst has `len`=`BURST_LEN`.

Decomposition:
- Package `sdram_pkg`:
  - State enum `{IDLE, REQ, DATA, DONE}`, 2-bit encoding.
  - `BURST_LEN` default constant.
  - Address-wrap helper function `wrap_addr(cur, len, base, end)`.
- One natural sub-module: `sdram_addr_gen`, holding the `cur_addr` register, wrap logic and base load.
- The FSM, beat counter and handshake stay in the top.

Test Plan:
- Full burst: `BURST_LEN`=8, write 8 words 0x1000..0x1007 into the FIFO, `enable`=1, `base_addr`=0x100.
  - Expect `sdr_wr_req` with addr 0x100, len 8.
  - After ack, with `sdr_wr_data_req` held high, expect 8 consecutive words 0x1000..0x1007 and `burst_done` one cycle after the 8th pull.
- Throttled pull: same 8 words, `sdr_wr_data_req` alternating 1/0.
  - Expect pops only on request cycles, data in order, no duplicates, `burst_done` after 8 pulls.
- Wrap: `base_addr`=0x100, `end_addr`=0x117, 32 words in the FIFO.
  - Expect burst addresses 0x100, 0x108, 0x110, 0x100.
- Threshold hold: FIFO holds 7 words, `enable`=1, `flush`=0.
  - Expect no `sdr_wr_req` for 100 cycles.
  - Adding one word must produce a request within 2 cycles.
- Flush (with `SDRAM_WR_FLUSH_EN`): 3 words in the FIFO, pulse `flush`.
  - Expect `sdr_wr_len`=3, three pops, then next addr = previous+3.
  - Without the macro, expect no request.
- Reset mid-burst: assert `rst_n`=0 after 4 of 8 pulls.
  - `sdr_wr_req`, `fifo_rd_req`, `busy` and `burst_done` go to 0 asynchronously.
  - After release, expect state IDLE and `cur_addr` = `base_addr`.
